// File: rtl/xc_malu_defs_pkg.sv
// Shared definitions for the divide/remainder sequencer: FSM encodings and
// fixed result constants.
package xc_malu_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] DBZ_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

endpackage

// File: rtl/xc_malu_neg32.sv
// Conditional two's-complement negate of a 32-bit value (mod 2^32).
// Purely combinational.
module xc_malu_neg32 (
  input  logic        neg_i,
  input  logic [31:0] val_i,
  output logic [31:0] res_o
);

  assign res_o = neg_i ? (~val_i + 32'd1) : val_i;

endmodule

// File: rtl/xc_malu_divrem_seq.sv
// Sequencer around the iterative divider: captures a div/rem request, runs the
// divider, applies RISC-V sign/div-by-zero fix-up and hands one result downstream.
module xc_malu_divrem_seq
  import xc_malu_defs::*;
#(
  parameter bit DBZ_FAST = 1'b1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        flush,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  input  logic        issue_signed,
  input  logic        issue_rem,
  output logic        div_valid,
  output logic [31:0] div_rs1,
  output logic [31:0] div_rs2,
  output logic        div_signed,
  input  logic        div_ready,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_dbz
);

  state_e      state_q, state_d;
  logic [31:0] rs1_q, rs2_q, raw_quot_q, raw_rem_q, res_data_q;
  logic        sgn_q, rem_q, res_dbz_q;
  logic        cap_en, raw_en, res_en;

  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    raw_en  = 1'b0;
    res_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (issue_valid) begin
        cap_en  = 1'b1;
        state_d = (DBZ_FAST && (issue_rs2 == '0)) ? ST_FIX : ST_RUN;
      end
      ST_RUN: if (div_ready) begin
        raw_en  = 1'b1;
        state_d = ST_FIX;
      end
      ST_FIX: begin
        res_en  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Flush wins over every transition, including a pending issue.
    if (flush) begin
      state_d = ST_IDLE;
      cap_en  = 1'b0;
      raw_en  = 1'b0;
      res_en  = 1'b0;
    end
  end

  logic        op_dbz, op_ovf, neg_q, neg_r;
  logic [31:0] quot_s, rem_s, fix_quot, fix_rem;

  assign op_dbz = (rs2_q == '0);
  assign op_ovf = sgn_q && (rs1_q == INT_MIN) && (rs2_q == '1);
  assign neg_q  = sgn_q & (rs1_q[31] ^ rs2_q[31]);
  assign neg_r  = sgn_q & rs1_q[31];

  xc_malu_neg32 u_neg_quot (.neg_i(neg_q), .val_i(raw_quot_q), .res_o(quot_s));
  xc_malu_neg32 u_neg_rem  (.neg_i(neg_r), .val_i(raw_rem_q),  .res_o(rem_s));

  // Divide-by-zero ignores whatever the divider produced (or skipped).
  assign fix_quot = op_dbz ? DBZ_QUOT : (op_ovf ? INT_MIN : quot_s);
  assign fix_rem  = op_dbz ? rs1_q    : (op_ovf ? '0      : rem_s);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      sgn_q      <= 1'b0;
      rem_q      <= 1'b0;
      raw_quot_q <= '0;
      raw_rem_q  <= '0;
      res_data_q <= '0;
      res_dbz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cap_en) begin
        rs1_q <= issue_rs1;
        rs2_q <= issue_rs2;
        sgn_q <= issue_signed;
        rem_q <= issue_rem;
      end
      if (raw_en) begin
        raw_quot_q <= div_quot;
        raw_rem_q  <= div_rem;
      end
      if (res_en) begin
        res_data_q <= rem_q ? fix_rem : fix_quot;
        res_dbz_q  <= op_dbz;
      end
    end
  end

  assign issue_ready = resetn && (state_q == ST_IDLE) && !flush;
  assign div_valid   = (state_q == ST_RUN);
  assign div_rs1     = rs1_q;
  assign div_rs2     = rs2_q;
  assign div_signed  = sgn_q;
  assign res_valid   = (state_q == ST_DONE);
  assign res_data    = res_data_q;
  assign res_dbz     = res_dbz_q;

endmodule
